// File: rtl/adder_seq_n_if.sv
// Handshake/operand bundle for the chunked sequential adder/subtractor.
// The master drives operands and out_ready; the slave (the adder) returns the result.
interface adder_seq_n_if #(
    parameter int unsigned N = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         c_in;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] sum;
    logic         c_out;
    logic         overflow;

    modport master (
        output in_valid, a, b, c_in, sub, out_ready,
        input  in_ready, out_valid, sum, c_out, overflow
    );

    modport slave (
        input  in_valid, a, b, c_in, sub, out_ready,
        output in_ready, out_valid, sum, c_out, overflow
    );
endinterface

// File: rtl/adder_seq_n.sv
// Multi-cycle adder/subtractor: adds CHUNK bits per cycle with the carry held in a flop,
// one transaction in flight, valid/ready on both sides.
module adder_seq_n #(
    parameter int unsigned N     = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic          clk,
    input  logic          rst,
    adder_seq_n_if.slave  bus
);
    localparam int unsigned STEPS = N / CHUNK;
    localparam int unsigned CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int unsigned CW1   = CHUNK + 1;

    if ((N % CHUNK) != 0 || CHUNK == 0) begin : g_param_check
        $error("adder_seq_n: N must be a non-zero multiple of CHUNK");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e           state_q, state_d;
    logic [N-1:0]     a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             c_out_q, c_out_d;
    logic             ovf_q, ovf_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [CHUNK-1:0] a_ch, b_ch, ch_sum;
    logic             ch_cy, msb_cin, last_step;

    // Select the operand chunk addressed by the step counter.
    always_comb begin
        a_ch = '0;
        b_ch = '0;
        for (int unsigned k = 0; k < STEPS; k++) begin
            if (cnt_q == CNT_W'(k)) begin
                a_ch = a_q[k*CHUNK +: CHUNK];
                b_ch = b_q[k*CHUNK +: CHUNK];
            end
        end
    end

    assign {ch_cy, ch_sum} = {1'b0, a_ch} + {1'b0, b_ch} + CW1'(carry_q);
    // Carry into the chunk MSB recovered from the MSB sum bit.
    assign msb_cin   = a_ch[CHUNK-1] ^ b_ch[CHUNK-1] ^ ch_sum[CHUNK-1];
    assign last_step = (cnt_q == CNT_W'(STEPS - 1));

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        sum_d     = sum_q;
        carry_d   = carry_q;
        cnt_d     = cnt_q;
        c_out_d   = c_out_q;
        ovf_d     = ovf_q;

        unique case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    a_d     = bus.a;
                    b_d     = bus.sub ? ~bus.b : bus.b;
                    carry_d = bus.sub ? 1'b1 : bus.c_in;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int unsigned k = 0; k < STEPS; k++) begin
                    if (cnt_q == CNT_W'(k)) begin
                        sum_d[k*CHUNK +: CHUNK] = ch_sum;
                    end
                end
                carry_d = ch_cy;
                cnt_d   = cnt_q + CNT_W'(1);
                if (last_step) begin
                    c_out_d = ch_cy;
                    ovf_d   = msb_cin ^ ch_cy;
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready && out_valid_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            c_out_q     <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            cnt_q       <= cnt_d;
            c_out_q     <= c_out_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.c_out     = c_out_q;
    assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_adder_seq_n.sv
// Directed and random checks of adder_seq_n in three configurations:
// N=32/CHUNK=8, N=8/CHUNK=4, N=16/CHUNK=16.
module tb_adder_seq_n;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    adder_seq_n_if #(.N(32)) if0 ();
    adder_seq_n_if #(.N(8))  if1 ();
    adder_seq_n_if #(.N(16)) if2 ();

    adder_seq_n #(.N(32), .CHUNK(8))  u_dut0 (.clk(clk), .rst(rst), .bus(if0));
    adder_seq_n #(.N(8),  .CHUNK(4))  u_dut1 (.clk(clk), .rst(rst), .bus(if1));
    adder_seq_n #(.N(16), .CHUNK(16)) u_dut2 (.clk(clk), .rst(rst), .bus(if2));

    logic        ov [3];
    logic        ir [3];
    logic        co [3];
    logic        of [3];
    logic [31:0] sm [3];

    assign ov[0] = if0.out_valid;  assign ov[1] = if1.out_valid;  assign ov[2] = if2.out_valid;
    assign ir[0] = if0.in_ready;   assign ir[1] = if1.in_ready;   assign ir[2] = if2.in_ready;
    assign co[0] = if0.c_out;      assign co[1] = if1.c_out;      assign co[2] = if2.c_out;
    assign of[0] = if0.overflow;   assign of[1] = if1.overflow;   assign of[2] = if2.overflow;
    assign sm[0] = if0.sum;        assign sm[1] = 32'(if1.sum);   assign sm[2] = 32'(if2.sum);

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(string tag, logic [63:0] got, logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int wid(int sel);
        case (sel)
            0:       return 32;
            1:       return 8;
            default: return 16;
        endcase
    endfunction

    function automatic int steps(int sel);
        case (sel)
            0:       return 4;
            1:       return 2;
            default: return 1;
        endcase
    endfunction

    // Reference: full-width add, then carry/overflow from sign bits.
    function automatic void model(int w, logic [31:0] a, logic [31:0] b, logic ci, logic s,
                                  output logic [31:0] es, output logic ec, output logic eo);
        logic [31:0] mask, am, bb;
        logic [32:0] full;
        logic        sa, sb, ss;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        am   = a & mask;
        bb   = s ? (~b & mask) : (b & mask);
        full = {1'b0, am} + {1'b0, bb} + 33'(s ? 1'b1 : ci);
        es   = full[31:0] & mask;
        ec   = 1'(full >> w);
        sa   = 1'(am >> (w - 1));
        sb   = 1'(bb >> (w - 1));
        ss   = 1'(es >> (w - 1));
        eo   = (sa == sb) && (ss != sa);
    endfunction

    task automatic set_in(int sel, logic v, logic [31:0] a, logic [31:0] b, logic ci, logic s);
        case (sel)
            0: begin if0.in_valid = v; if0.a = a;       if0.b = b;       if0.c_in = ci; if0.sub = s; end
            1: begin if1.in_valid = v; if1.a = a[7:0];  if1.b = b[7:0];  if1.c_in = ci; if1.sub = s; end
            default: begin if2.in_valid = v; if2.a = a[15:0]; if2.b = b[15:0]; if2.c_in = ci; if2.sub = s; end
        endcase
    endtask

    task automatic set_rdy(int sel, logic r);
        case (sel)
            0:       if0.out_ready = r;
            1:       if1.out_ready = r;
            default: if2.out_ready = r;
        endcase
    endtask

    // One full transaction; hold = cycles of backpressure, poke = offer a second operand meanwhile.
    task automatic do_tx(int sel, logic [31:0] a, logic [31:0] b, logic ci, logic s, int hold, bit poke);
        logic [31:0] es;
        logic        ec, eo;
        int          lat;
        model(wid(sel), a, b, ci, s, es, ec, eo);
        set_in(sel, 1'b1, a, b, ci, s);
        lat = 0;
        while (!ir[sel] && lat < 32) begin @(posedge clk); #1; lat++; end
        check_eq("in_ready_before_accept", 64'(ir[sel]), 64'd1);
        @(posedge clk); #1;
        set_in(sel, 1'b0, $urandom, $urandom, 1'($urandom), 1'($urandom));
        check_eq("in_ready_in_run", 64'(ir[sel]), 64'd0);
        lat = 0;
        while (!ov[sel] && lat < 64) begin @(posedge clk); #1; lat++; end
        check_eq("latency", 64'(lat), 64'(steps(sel)));
        check_eq("sum", 64'(sm[sel]), 64'(es));
        check_eq("c_out", 64'(co[sel]), 64'(ec));
        check_eq("overflow", 64'(of[sel]), 64'(eo));
        for (int h = 0; h < hold; h++) begin
            if (poke) set_in(sel, 1'b1, ~a, b ^ 32'h5A5A_5A5A, ~ci, ~s);
            @(posedge clk); #1;
            check_eq("hold_valid", 64'(ov[sel]), 64'd1);
            check_eq("hold_in_ready", 64'(ir[sel]), 64'd0);
            check_eq("hold_sum", 64'(sm[sel]), 64'(es));
            check_eq("hold_flags", {62'd0, co[sel], of[sel]}, {62'd0, ec, eo});
        end
        set_in(sel, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        set_rdy(sel, 1'b1);
        @(posedge clk); #1;
        set_rdy(sel, 1'b0);
        check_eq("consumed_valid", 64'(ov[sel]), 64'd0);
        check_eq("consumed_in_ready", 64'(ir[sel]), 64'd1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int s = 0; s < 3; s++) begin
            set_in(s, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
            set_rdy(s, 1'b0);
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        for (int s = 0; s < 3; s++) begin
            check_eq("rst_in_ready", 64'(ir[s]), 64'd1);
            check_eq("rst_out_valid", 64'(ov[s]), 64'd0);
            check_eq("rst_sum", 64'(sm[s]), 64'd0);
            check_eq("rst_flags", {62'd0, co[s], of[s]}, 64'd0);
        end

        // Abort mid-RUN: partial result must never surface.
        set_in(0, 1'b1, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 1'b0);
        @(posedge clk); #1;
        set_in(0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("abort_in_ready", 64'(ir[0]), 64'd1);
        check_eq("abort_out_valid", 64'(ov[0]), 64'd0);
        check_eq("abort_sum", 64'(sm[0]), 64'd0);
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            check_eq("abort_no_stale", 64'(ov[0]), 64'd0);
        end

        // Directed vectors.
        do_tx(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0, 1'b0);
        do_tx(0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0, 1'b0);
        do_tx(1, 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 0, 1'b0);
        do_tx(1, 32'h0000_0080, 32'h0000_0001, 1'b0, 1'b1, 0, 1'b0);
        do_tx(2, 32'h0000_FFFF, 32'h0000_0001, 1'b1, 1'b0, 0, 1'b0);
        do_tx(2, 32'h0000_8000, 32'h0000_8000, 1'b0, 1'b0, 0, 1'b0);
        do_tx(0, 32'h0000_0000, 32'h0000_0001, 1'b1, 1'b1, 0, 1'b0);

        // Backpressure with a competing operand offered, then the next pair.
        do_tx(0, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 10, 1'b1);
        do_tx(0, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 0, 1'b0);

        // Random back-to-back traffic with random consumer stalls.
        for (int s = 0; s < 3; s++) begin
            for (int i = 0; i < 1000; i++) begin
                do_tx(s, $urandom, $urandom, 1'($urandom), 1'($urandom),
                      int'($urandom_range(0, 3)), 1'($urandom));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/adder_seq_n.md
Name: adder_seq_n

Overview:
- Multi-cycle chunked adder/subtractor, the sequential successor to the N-bit ripple-carry adder.
- Holds operands in registers and processes CHUNK bits per cycle, keeping the carry in a flop between chunks.
- Trades latency for a short critical path, so wide arithmetic does not limit the clock.
- Valid/ready handshakes on input and output let it sit between pipeline stages or a controller FSM.

Parameters:
- N, 32, operand/result width in bits; must be a multiple of CHUNK.
- CHUNK, 8, bits added per cycle. STEPS = N/CHUNK. CHUNK = N gives a 1-step adder.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands/mode present.
- in_ready  output  1  block can accept operands.
- a  input  N  operand A.
- b  input  N  operand B.
- c_in  input  1  carry in; used only when sub=0.
- sub  input  1  0: a+b+c_in; 1: a-b (a + ~b + 1).
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- sum  output  N  result.
- c_out  output  1  final carry out (for sub: 1 means no borrow).
- overflow  output  1  signed overflow of the N-bit operation.

Behaviour:
- Reset: one clk edge with rst=1 forces state IDLE, in_ready=1, out_valid=0, sum=0, c_out=0, overflow=0, step counter=0, carry flop=0.
- rst is sampled every edge. Reset mid-operation aborts the operation; the partial result is discarded and never presented.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid & in_ready: latch a and (sub ? ~b : b); carry flop = sub ? 1 : c_in; latch sub; counter=0; go to RUN.
  - Otherwise remain in IDLE.
- RUN:
  - in_ready=0, out_valid=0.
  - Each cycle, adds chunk k = counter, bits [k*CHUNK +: CHUNK], with the carry flop.
  - Writes sum chunk k; carry flop = chunk carry out; counter++.
  - On the cycle with counter == STEPS-1, also register c_out = final carry and overflow = carry into MSB XOR carry out of MSB; go to DONE.
- Latency: accept at edge t. out_valid is high after edge t+STEPS, so it is first visible in the cycle after the STEPS-th RUN edge.
- DONE:
  - out_valid=1; sum, c_out and overflow held stable; in_ready=0.
  - On out_valid & out_ready: go to IDLE (out_valid=0 next cycle).
  - out_ready low holds DONE indefinitely (backpressure); output must not change.
- No new operand is accepted until the result is consumed: one transaction in flight, no bypass. Throughput is one result per STEPS+2 cycles minimum.
- sum bits not yet written in RUN are don't-care while out_valid=0. The verifier checks sum only when out_valid=1.
- Operand inputs may change freely after acceptance; the latched copies are used.
- in_valid while in_ready=0 is ignored; the producer must hold in_valid until the handshake.
- Arithmetic is modulo 2^N, unsigned wrap. Carry out is reported on c_out, not folded into sum.
- Subtraction computes a-b exactly; c_in is ignored.

Test Plan:
- Reset: hold rst 2 cycles mid-RUN with N=32, CHUNK=8 -> after release in_ready=1, out_valid=0, sum=0; no stale result ever appears.
- Add with carry chain: N=32, CHUNK=8, a=0xFFFFFFFF, b=0x00000001, c_in=0 -> out_valid exactly 4 cycles after accept; sum=0x00000000, c_out=1, overflow=0.
- Signed overflow: a=0x7FFFFFFF, b=0x00000001, sub=0 -> sum=0x80000000, c_out=0, overflow=1.
- Subtract: N=8, CHUNK=4, a=0x05, b=0x07, sub=1, c_in=1 -> sum=0xFE, c_out=0 (borrow), overflow=0, out_valid after 2 cycles. Then a=0x80, b=0x01, sub=1 -> sum=0x7F, c_out=1, overflow=1.
- Backpressure and handshake:
  - Hold out_ready=0 for 10 cycles -> sum/flags stable, in_ready=0, a second in_valid is ignored.
  - Raise out_ready -> IDLE next cycle; the next operand pair is accepted and its result is correct.
- Degenerate and random: CHUNK=N=16 (1 step) -> latency 1; then 1000 random back-to-back transactions with random out_ready, all params -> results match a reference model a+b+c_in / a-b.
